freq_gate_counter: RTL

- Upstream stage of the binary-to-BCD converter in the frequency counter.
- Synchronizes an external input signal and counts its rising edges over a fixed gate window of GATE_CYCLES clocks.
- At the end of each window it latches the count onto the 32-bit freq bus, where it is held stable for the BCD stage and display.
- Gates run back-to-back while enable is high, so freq updates once per window; the default window gives 1 s at 50 MHz, i.e. freq in Hz.

---
 rtl/freq_gate_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clocks and publishes each completed count on freq.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  input  logic        enable,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic        overflow,
  output logic        gate_active
);

  localparam int unsigned    GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam int unsigned    MW        = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0]  MASK_LEN  = MW'(SYNC_STAGES + 1);

  typedef enum logic {IDLE, GATE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   strobe;
  logic [MW-1:0]          mask_cnt;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   ovf;
  logic                   ovf_next;

  // Strobe is suppressed until the chain has flushed its reset zeros, so a
  // level already high at reset release is never mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      prev     <= 1'b0;
      strobe   <= 1'b0;
      mask_cnt <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      prev   <= sync[SYNC_STAGES-1];
      strobe <= sync[SYNC_STAGES-1] & ~prev & (mask_cnt == MASK_LEN);
      if (mask_cnt != MASK_LEN) mask_cnt <= mask_cnt + MW'(1);
    end
  end

  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf;
    if (strobe) begin
      if (edge_cnt == '1) ovf_next = 1'b1;
      else                cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  // The terminal cycle publishes cnt_next so a strobe landing on it still
  // belongs to the closing window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf         <= 1'b0;
      freq        <= '0;
      freq_valid  <= 1'b0;
      overflow    <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= GATE;
            gate_active <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
          end
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            freq       <= 32'(cnt_next);
            overflow   <= ovf_next;
            freq_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            if (!enable) begin
              state       <= IDLE;
              gate_active <= 1'b0;
            end
          end else if (!enable) begin
            state       <= IDLE;
            gate_active <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= cnt_next;
            ovf      <= ovf_next;
          end
        end
      endcase
    end
  end

endmodule
